// File: rtl/psram_pkg.sv
// Shared types for the PSRAM burst arbiter: FSM state encoding and requester count.
package psram_pkg;

  localparam int unsigned NumReq = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StWait,
    StXfer,
    StDone
  } psram_state_e;

  // Counter width for a count running 0..last_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned last_val);
    return (last_val > 0) ? $clog2(last_val + 1) : 1;
  endfunction

endpackage

// File: rtl/psram_arb_select.sv
// Combinational winner selection for the two PSRAM requesters.
// Macro PSRAM_ARB_FIXED_PRIORITY_EN: requester 0 always wins a tie; otherwise the
// round-robin pointer wins a tie.
module psram_arb_select
  import psram_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic              ptr_i,
  output logic              valid_o,
  output logic              idx_o
);

`ifdef PSRAM_ARB_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

  // Pick the winning requester index.
  always_comb begin
    valid_o = |req_i;
`ifdef PSRAM_ARB_FIXED_PRIORITY_EN
    idx_o = ~req_i[0];
`else
    if (&req_i) begin
      idx_o = ptr_i;
    end else begin
      idx_o = req_i[1];
    end
`endif
  end

endmodule

// File: rtl/psram_burst_arbiter.sv
// Two-requester arbiter sequencing bursts onto a single PSRAM burst controller.
// Optional macro PSRAM_ARB_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module psram_burst_arbiter
  import psram_pkg::*;
#(
  parameter int unsigned address_width  = 16,
  parameter int unsigned data_width     = 16,
  parameter int unsigned access_latency = 1,
  parameter int unsigned burst_size     = 31
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [2*address_width-1:0]    adr_i,
  input  logic [2*data_width-1:0]       dat_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             done_o,
  output logic [NumReq-1:0]             wr_req_o,
  output logic [NumReq-1:0]             rd_vld_o,
  output logic [data_width-1:0]         dat_o,
  output logic                          ctrl_start_o,
  output logic                          ctrl_we_o,
  output logic [address_width-1:0]      ctrl_adr_o,
  output logic [data_width-1:0]         ctrl_dat_o,
  input  logic [data_width-1:0]         ctrl_dat_i
);

  localparam int unsigned WaitW = cnt_width(access_latency);
  localparam int unsigned BeatW = cnt_width(burst_size);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(access_latency);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(burst_size);

  psram_state_e             state_q, state_d;
  logic                     idx_q, idx_d;
  logic                     we_q, we_d;
  logic [address_width-1:0] adr_q, adr_d;
  logic                     gnt_q, gnt_d;
  logic                     ptr_q, ptr_d;
  logic [WaitW-1:0]         wait_q, wait_d;
  logic [BeatW-1:0]         beat_q, beat_d;

  logic sel_valid, sel_idx;
  logic start, wr_req, rd_vld, done;
  logic [NumReq-1:0] req_oh;

  psram_arb_select u_select (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // State and latched-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    adr_d   = adr_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    start   = 1'b0;
    wr_req  = 1'b0;
    rd_vld  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          idx_d   = sel_idx;
          we_d    = we_i[sel_idx];
          adr_d   = sel_idx ? adr_i[2*address_width-1:address_width] : adr_i[address_width-1:0];
          gnt_d   = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        start   = 1'b1;
        state_d = StAddr;
      end
      StAddr: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          // First write word leads by one cycle to fill the controller's input register.
          wr_req  = we_q;
          beat_d  = '0;
          state_d = StXfer;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StXfer: begin
        wr_req = we_q && (beat_q != BeatLast);
        rd_vld = !we_q && (beat_q != '0);
        if (beat_q == BeatLast) begin
          state_d = StDone;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        rd_vld  = !we_q;
        gnt_d   = 1'b0;
        ptr_d   = ~idx_q;
        beat_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_oh       = {idx_q, ~idx_q};
  assign gnt_o        = gnt_q  ? req_oh : '0;
  assign done_o       = done   ? req_oh : '0;
  assign wr_req_o     = wr_req ? req_oh : '0;
  assign rd_vld_o     = rd_vld ? req_oh : '0;
  assign ctrl_start_o = start;
  assign ctrl_we_o    = we_q;
  assign ctrl_adr_o   = adr_q;
  assign ctrl_dat_o   = idx_q ? dat_i[2*data_width-1:data_width] : dat_i[data_width-1:0];
  assign dat_o        = ctrl_dat_i;

endmodule

// File: tb/tb_psram_burst_arbiter.sv
// Self-checking bench for psram_burst_arbiter (honours PSRAM_ARB_FIXED_PRIORITY_EN).
module tb_psram_burst_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int AL = 1;
  localparam int BS = 31;
  // Burst timeline, counted in cycles from acceptance (offset 0 = controller start cycle).
  localparam int WrFirst = 2 + AL;
  localparam int WrLast  = 2 + AL + BS;
  localparam int XferOff = 3 + AL;
  localparam int DoneOff = 4 + AL + BS;
`ifdef PSRAM_ARB_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic [1:0]      req_i, we_i;
  logic [2*AW-1:0] adr_i;
  logic [2*DW-1:0] dat_i;
  logic [1:0]      gnt_o, done_o, wr_req_o, rd_vld_o;
  logic [DW-1:0]   dat_o, ctrl_dat_o, ctrl_dat_i;
  logic [AW-1:0]   ctrl_adr_o;
  logic            ctrl_start_o, ctrl_we_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: offset into current burst (-1 when idle) and arbitration data.
  int            k = -1;
  int            m_idx = 0;
  int            m_ptr = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  int            wr_cnt, rd_cnt;
  logic [1:0]    obs_gnt[$];

  always #5 clk = ~clk;

  psram_burst_arbiter #(
    .address_width  (AW),
    .data_width     (DW),
    .access_latency (AL),
    .burst_size     (BS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .adr_i        (adr_i),
    .dat_i        (dat_i),
    .gnt_o        (gnt_o),
    .done_o       (done_o),
    .wr_req_o     (wr_req_o),
    .rd_vld_o     (rd_vld_o),
    .dat_o        (dat_o),
    .ctrl_start_o (ctrl_start_o),
    .ctrl_we_o    (ctrl_we_o),
    .ctrl_adr_o   (ctrl_adr_o),
    .ctrl_dat_o   (ctrl_dat_o),
    .ctrl_dat_i   (ctrl_dat_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the burst timeline says for the current offset.
  task automatic check_cycle();
    logic [1:0] oh;
    bit act, wr, rd;
    oh  = (m_idx == 1) ? 2'b10 : 2'b01;
    act = (k >= 0);
    wr  = act && m_we && (k >= WrFirst) && (k <= WrLast);
    rd  = act && !m_we && (k >= XferOff + 1) && (k <= DoneOff);
    if (k == 0) begin
      wr_cnt = 0;
      rd_cnt = 0;
      obs_gnt.push_back(gnt_o);
    end
    check("gnt", 64'(gnt_o), act ? 64'(oh) : 64'd0);
    check("start", 64'(ctrl_start_o), 64'(k == 0));
    check("wr_req", 64'(wr_req_o), wr ? 64'(oh) : 64'd0);
    check("rd_vld", 64'(rd_vld_o), rd ? 64'(oh) : 64'd0);
    check("done", 64'(done_o), (k == DoneOff) ? 64'(oh) : 64'd0);
    check("dat_o", 64'(dat_o), 64'(ctrl_dat_i));
    if (act) begin
      check("ctrl_adr", 64'(ctrl_adr_o), 64'(m_adr));
      check("ctrl_we", 64'(ctrl_we_o), 64'(m_we));
      if (wr_req_o[m_idx]) wr_cnt++;
      if (rd_vld_o[m_idx]) rd_cnt++;
    end
    if (wr) check("ctrl_dat", 64'(ctrl_dat_o), 64'(dat_i[m_idx*DW +: DW]));
    if (k == DoneOff) begin
      check("beats", 64'(m_we ? wr_cnt : rd_cnt), 64'(BS + 1));
    end
  endtask

  // Advance one clock and update the model from the inputs sampled at that edge.
  task automatic step();
    @(posedge clk);
    if (rst_i) begin
      k = -1;
      m_ptr = 0;
    end else if (k < 0) begin
      if (req_i != 2'b00) begin
        if (req_i == 2'b11) m_idx = Fixed ? 0 : m_ptr;
        else m_idx = req_i[1] ? 1 : 0;
        m_we  = we_i[m_idx];
        m_adr = adr_i[m_idx*AW +: AW];
        k = 0;
      end
    end else if (k == DoneOff) begin
      k = -1;
      m_ptr = 1 - m_idx;
    end else begin
      k++;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    ctrl_dat_i = DW'($urandom);
    dat_i      = {DW'($urandom), DW'($urandom)};
    #1;
    check_cycle();
    step();
  endtask

  task automatic finish_burst();
    for (int i = 0; i < DoneOff + 2 && k >= 0; i++) cyc();
    check("burst_ends", 64'(k), 64'hffff_ffff_ffff_ffff);
  endtask

  initial begin
    int gap;
    rst_i = 1'b1;
    req_i = '0;
    we_i  = '0;
    adr_i = '0;
    dat_i = '0;
    ctrl_dat_i = '0;
    @(negedge clk);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();

    // Single read from requester 0.
    req_i = 2'b01; we_i = 2'b00; adr_i = {16'h1234, 16'h0040};
    cyc();
    req_i = 2'b00;
    finish_burst();
    cyc();

    // Single write from requester 1.
    req_i = 2'b10; we_i = 2'b10; adr_i = {16'h0abc, 16'h0000};
    cyc();
    req_i = 2'b00;
    finish_burst();
    cyc();

    // Both requesting, held across three bursts.
    obs_gnt.delete();
    req_i = 2'b11; we_i = 2'b01; adr_i = {16'h2000, 16'h1000};
    for (int i = 0; i < 3 * (DoneOff + 2) + 2 && obs_gnt.size() < 3; i++) cyc();
    req_i = 2'b00;
    finish_burst();
    check("order_n", 64'(obs_gnt.size()), 64'd3);
    if (obs_gnt.size() == 3) begin
      check("order0", 64'(obs_gnt[0]), 64'(2'b01));
      check("order1", 64'(obs_gnt[1]), Fixed ? 64'(2'b01) : 64'(2'b10));
      check("order2", 64'(obs_gnt[2]), 64'(2'b01));
    end
    cyc();

    // Reset during XFER beat 10, then a fresh write burst.
    req_i = 2'b01; we_i = 2'b00; adr_i = {16'h0000, 16'h0200};
    cyc();
    req_i = 2'b00;
    for (int i = 0; i < DoneOff && k < XferOff + 10; i++) cyc();
    check("at_beat10", 64'(k), 64'(XferOff + 10));
    rst_i = 1'b1;
    k = -1;
    m_ptr = 0;
    cyc();
    rst_i = 1'b0;
    cyc();
    req_i = 2'b10; we_i = 2'b10; adr_i = {16'h0777, 16'h0000};
    cyc();
    req_i = 2'b00;
    finish_burst();
    cyc();

    // Requester 1 arrives mid-burst of requester 0.
    req_i = 2'b01; we_i = 2'b00; adr_i = {16'h0300, 16'h0100};
    cyc();
    req_i = 2'b00;
    for (int i = 0; i < 20; i++) cyc();
    req_i = 2'b10;
    finish_burst();
    gap = 0;
    for (int i = 0; i < 4 && gnt_o == 2'b00; i++) begin
      gap++;
      cyc();
    end
    check("idle_gap", 64'(gap), 64'd1);
    req_i = 2'b00;
    finish_burst();

    // Randomised traffic; requests during a burst must be ignored.
    for (int i = 0; i < 800; i++) begin
      req_i = 2'($urandom_range(0, 3));
      we_i  = 2'($urandom);
      adr_i = {AW'($urandom), AW'($urandom)};
      cyc();
    end
    req_i = 2'b00;
    finish_burst();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psram_burst_arbiter.md
PSRAM_BURST_ARBITER -- requirements
Module: psram_burst_arbiter

Interface
REQ-001 SHALL have parameters: address_width, default 16, word address width; data_width, default 16, data width; access_latency, default 1, must match the burst controller; burst_size, default 31, last beat index, giving burst_size+1 beats.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_i, input, 2 bits: per-requester burst request, held until that requester's gnt_o.
REQ-005 SHALL have port we_i, input, 2 bits: per-requester direction; 1 = write, 0 = read.
REQ-006 SHALL have port adr_i, input, 2*address_width bits: per-requester start address; requester n uses slice n.
REQ-007 SHALL have port dat_i, input, 2*data_width bits: per-requester write data; requester n uses slice n.
REQ-008 SHALL have port gnt_o, output, 2 bits, one-hot or zero: held from acceptance until done.
REQ-009 SHALL have port done_o, output, 2 bits: one-cycle pulse per requester at burst end.
REQ-010 SHALL have port wr_req_o, output, 2 bits: granted requester presents the next write word this cycle.
REQ-011 SHALL have port rd_vld_o, output, 2 bits: dat_o holds a valid read word for the granted requester.
REQ-012 SHALL have port dat_o, output, data_width bits: read data, passed through from the controller.
REQ-013 SHALL have ports ctrl_start_o, ctrl_we_o, ctrl_adr_o and ctrl_dat_o (outputs) and ctrl_dat_i (input): these drive the burst controller's start_i, we_i, adr_i, dat_i and receive its dat_o.

Function
REQ-014 SHALL implement states IDLE, START, ADDR, WAIT, XFER and DONE in a registered FSM.
REQ-015 SHALL, in IDLE with any req_i bit set, latch the winner's index, we and adr; set gnt_o; and go to START.
REQ-016 SHALL drive ctrl_start_o=1 only in START, with ctrl_adr_o/ctrl_we_o from the latched values; then go to ADDR (1 cycle).
REQ-017 SHALL stay in WAIT for access_latency+1 cycles, then go to XFER.
REQ-018 SHALL stay in XFER for burst_size+1 cycles, with a beat counter running 0..burst_size, then go to DONE.
REQ-019 SHALL, in DONE, pulse done_o for the granted requester, clear gnt_o on the next edge, and return to IDLE.
REQ-020 SHALL, for writes, assert wr_req_o in the last WAIT cycle and in XFER beats 0..burst_size-1, muxing the granted dat_i slice to ctrl_dat_o (one-cycle lead for the controller's input register).
REQ-021 SHALL, for reads, assert rd_vld_o in XFER beats 1..burst_size and in DONE, i.e. burst_size+1 pulses.
REQ-022 SHALL sample req_i only in IDLE; requests that drop or change during a burst are ignored.
REQ-023 SHALL guarantee a minimum of one IDLE cycle between bursts.
REQ-024 SHALL keep all per-requester outputs zero for the non-granted requester.
REQ-025 SHALL size the beat counter to ceil(log2(burst_size+1)) bits, and it SHALL never wrap within a burst.

Reset
REQ-026 SHALL, on rst_i asserted (including mid-burst), immediately force IDLE, clear gnt_o, done_o, wr_req_o, rd_vld_o and ctrl_start_o to 0, clear the counters, and set the round-robin pointer to requester 0.
REQ-027 SHALL rely on the same rst_i also resetting the burst controller; no partial burst SHALL resume after reset.

Configuration
REQ-028 SHALL support macro PSRAM_ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins simultaneous requests; when undefined, round-robin applies, with the pointer moving to the other requester after each DONE and a tie won by the pointer.

Structure
REQ-029 SHALL place the state encodings and the 2-requester count in a shared package psram_pkg.
REQ-030 SHALL place selection logic in sub-module psram_arb_select (combinational winner from req, pointer and macro).

Verification
REQ-031 SHALL cover: single read, req_i=01, we_i=00, adr0=16'h0040 -> ctrl_start_o 1 cycle with ctrl_adr_o=16'h0040, 32 rd_vld_o[0] pulses, done_o[0] pulse, gnt_o back to 00.
REQ-032 SHALL cover: single write, req_i=10, we_i=10 -> 32 wr_req_o[1] pulses starting in the last WAIT cycle; ctrl_dat_o tracks dat_i slice 1.
REQ-033 SHALL cover: simultaneous req_i=11 held for 3 bursts -> grant order 0,1,0 (round-robin) or 0,0,0 (PSRAM_ARB_FIXED_PRIORITY_EN).
REQ-034 SHALL cover: rst_i pulsed in XFER beat 10 -> all outputs 0 in the same cycle; the next request restarts from START.
REQ-035 SHALL cover: req_i[1] rising mid-burst of requester 0 -> no effect until IDLE; then granted, with at least one IDLE cycle between bursts.
